// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: width, taps, FSM state encoding and next-state function
// for the x^7+x^6+1 maximal-length sequence.
package lfsr_pkg;

    localparam int unsigned LFSR_W = 7;
    localparam int unsigned TAP_HI = 6;
    localparam int unsigned TAP_LO = 5;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_CHECK,
        ST_LOCKED
    } state_e;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
    endfunction

endpackage

// File: rtl/lfsr_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module lfsr_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/lfsr_seq_checker.sv
// Checks an upstream 7-bit LFSR word stream with parity; HUNT/CHECK/LOCKED tracking.
// Optional period measurement output enabled by macro LFSR_CHK_PERIOD_EN.
module lfsr_seq_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned LOCK_CNT = 3,
    parameter int unsigned LOSS_CNT = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_word,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             par_err,
    output logic             seq_err,
    output logic [CNT_W-1:0] par_cnt,
    output logic [CNT_W-1:0] seq_cnt
`ifdef LFSR_CHK_PERIOD_EN
    ,
    output logic [7:0]       period,
    output logic             period_vld
`endif
);

    localparam int unsigned MAXC = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    state_e            state_q, state_d;
    logic [LFSR_W-1:0] pred_q, pred_d;
    logic [CW-1:0]     match_q, match_d;
    logic [CW-1:0]     miss_q, miss_d;
    logic              locked_q, locked_d;
    logic              par_err_q, par_err_d;
    logic              seq_err_q, seq_err_d;
    logic [LFSR_W-1:0] word_s;
    logic              hit;
    logic              par_bad;

    assign word_s  = in_word[LFSR_W-1:0];
    assign hit     = (word_s == pred_q);
    assign par_bad = in_word[7] ^ (^word_s);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_HUNT;
            pred_q    <= '0;
            match_q   <= '0;
            miss_q    <= '0;
            locked_q  <= 1'b0;
            par_err_q <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pred_q    <= pred_d;
            match_q   <= match_d;
            miss_q    <= miss_d;
            locked_q  <= locked_d;
            par_err_q <= par_err_d;
            seq_err_q <= seq_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pred_d  = pred_q;
        match_d = match_q;
        miss_d  = miss_q;
        if (in_valid) begin
            unique case (state_q)
                ST_HUNT: begin
                    if (word_s != '0) begin
                        pred_d  = lfsr_next(word_s);
                        match_d = '0;
                        state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (hit) begin
                        pred_d = lfsr_next(word_s);
                        if (match_q == CW'(LOCK_CNT - 1)) begin
                            match_d = '0;
                            miss_d  = '0;
                            state_d = ST_LOCKED;
                        end else begin
                            match_d = match_q + 1'b1;
                        end
                    end else if (word_s != '0) begin
                        pred_d  = lfsr_next(word_s);
                        match_d = '0;
                    end else begin
                        // an all-zero word cannot seed; fall back to hunting
                        match_d = '0;
                        state_d = ST_HUNT;
                    end
                end
                ST_LOCKED: begin
                    // free-run from the prediction so one bad word costs one error
                    pred_d = lfsr_next(pred_q);
                    if (hit) begin
                        miss_d = '0;
                    end else if (miss_q == CW'(LOSS_CNT - 1)) begin
                        miss_d  = '0;
                        state_d = ST_HUNT;
                    end else begin
                        miss_d = miss_q + 1'b1;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    always_comb begin
        par_err_d = in_valid & par_bad;
        seq_err_d = in_valid & (state_q == ST_LOCKED) & ~hit;
        locked_d  = (state_d == ST_LOCKED);
    end

    assign locked  = locked_q;
    assign par_err = par_err_q;
    assign seq_err = seq_err_q;

    lfsr_sat_counter #(.W(CNT_W)) u_par_cnt (
        .clk (clk),
        .rst (rst),
        .inc (par_err_d),
        .clr (clr_cnt),
        .cnt (par_cnt)
    );

    lfsr_sat_counter #(.W(CNT_W)) u_seq_cnt (
        .clk (clk),
        .rst (rst),
        .inc (seq_err_d),
        .clr (clr_cnt),
        .cnt (seq_cnt)
    );

`ifdef LFSR_CHK_PERIOD_EN
    logic [LFSR_W-1:0] seed_q;
    logic [7:0]        pcnt_q;
    logic [7:0]        pcnt_inc;
    logic [7:0]        period_q;
    logic              period_vld_q;

    assign pcnt_inc = (pcnt_q == '1) ? pcnt_q : pcnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seed_q       <= '0;
            pcnt_q       <= '0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
        end else begin
            period_vld_q <= 1'b0;
            if ((state_q == ST_CHECK) && (state_d == ST_LOCKED)) begin
                seed_q <= word_s;
                pcnt_q <= '0;
            end else if (state_q == ST_LOCKED) begin
                if (state_d != ST_LOCKED) begin
                    pcnt_q <= '0;
                end else if (in_valid) begin
                    if (word_s == seed_q) begin
                        period_q     <= pcnt_inc;
                        period_vld_q <= 1'b1;
                        pcnt_q       <= '0;
                    end else begin
                        pcnt_q <= pcnt_inc;
                    end
                end
            end
        end
    end

    assign period     = period_q;
    assign period_vld = period_vld_q;
`endif

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed scoreboard bench for lfsr_seq_checker; period checks need LFSR_CHK_PERIOD_EN.
module tb_lfsr_seq_checker;

    localparam int unsigned LOCK_CNT = 3;
    localparam int unsigned LOSS_CNT = 4;
    localparam int unsigned CNT_W    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_word = '0;
    logic             clr_cnt = 1'b0;
    logic             locked, par_err, seq_err;
    logic [CNT_W-1:0] par_cnt, seq_cnt;
`ifdef LFSR_CHK_PERIOD_EN
    logic [7:0]       period;
    logic             period_vld;
    int               nvld = 0;
    logic             per_en = 1'b0;
`endif

    lfsr_seq_checker #(
        .LOCK_CNT (LOCK_CNT),
        .LOSS_CNT (LOSS_CNT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_word  (in_word),
        .clr_cnt  (clr_cnt),
        .locked   (locked),
        .par_err  (par_err),
        .seq_err  (seq_err),
        .par_cnt  (par_cnt),
        .seq_cnt  (seq_cnt)
`ifdef LFSR_CHK_PERIOD_EN
        ,
        .period     (period),
        .period_vld (period_vld)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             locked;
        logic             par_err;
        logic             seq_err;
        logic [CNT_W-1:0] par_cnt;
        logic [CNT_W-1:0] seq_cnt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    int               m_state;
    logic [6:0]       m_pred;
    int unsigned      m_match, m_miss;
    logic [CNT_W-1:0] m_pcnt, m_scnt;
    logic [6:0]       s;
    logic [6:0]       c;

    function automatic logic [6:0] nxt(input logic [6:0] x);
        return {x[5:0], x[6] ^ x[5]};
    endfunction

    function automatic logic [7:0] mk(input logic [6:0] x);
        return {^x, x};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_pred = '0; m_match = 0; m_miss = 0;
        m_pcnt = '0; m_scnt = '0;
        sb.delete();
    endtask

    task automatic model_step(input logic v, input logic [7:0] w, input logic clr);
        logic [6:0] x;
        logic pe, se;
        exp_t e;
        x = w[6:0];
        pe = 1'b0;
        se = 1'b0;
        if (v) begin
            pe = (w[7] != ^x);
            if (m_state == 0) begin
                if (x != 0) begin m_pred = nxt(x); m_match = 0; m_state = 1; end
            end else if (m_state == 1) begin
                if (x == m_pred) begin
                    m_pred = nxt(x);
                    m_match++;
                    if (m_match == LOCK_CNT) begin m_state = 2; m_miss = 0; m_match = 0; end
                end else if (x != 0) begin
                    m_pred = nxt(x); m_match = 0;
                end else begin
                    m_match = 0; m_state = 0;
                end
            end else begin
                se = (x != m_pred);
                m_pred = nxt(m_pred);
                if (se) begin
                    m_miss++;
                    if (m_miss == LOSS_CNT) begin m_state = 0; m_miss = 0; end
                end else begin
                    m_miss = 0;
                end
            end
        end
        if (clr) begin
            m_pcnt = '0; m_scnt = '0;
        end else begin
            if (pe && m_pcnt != {CNT_W{1'b1}}) m_pcnt = m_pcnt + 1'b1;
            if (se && m_scnt != {CNT_W{1'b1}}) m_scnt = m_scnt + 1'b1;
        end
        e.locked  = (m_state == 2);
        e.par_err = pe;
        e.seq_err = se;
        e.par_cnt = m_pcnt;
        e.seq_cnt = m_scnt;
        sb.push_back(e);
    endtask

    task automatic cyc(input logic v, input logic [7:0] w, input logic clr);
        exp_t e;
        in_valid = v;
        in_word  = w;
        clr_cnt  = clr;
        model_step(v, w, clr);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("locked",  locked,  e.locked);
        chk("par_err", par_err, e.par_err);
        chk("seq_err", seq_err, e.seq_err);
        chk("par_cnt", par_cnt, e.par_cnt);
        chk("seq_cnt", seq_cnt, e.seq_cnt);
`ifdef LFSR_CHK_PERIOD_EN
        if (per_en && period_vld) begin
            chk("period", period, 127);
            nvld++;
        end
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_locked",  locked,  0);
        chk("rst_par_err", par_err, 0);
        chk("rst_seq_err", seq_err, 0);
        chk("rst_par_cnt", par_cnt, 0);
        chk("rst_seq_cnt", seq_cnt, 0);
        rst = 1'b1;

        repeat (3) cyc(1'b1, 8'h00, 1'b0);
        chk("zero_no_lock", locked, 0);

        s = 7'h01;
        for (int i = 0; i < 200; i++) begin
            cyc(1'b1, mk(s), 1'b0);
            if (i == 2) chk("not_locked_w3", locked, 0);
            if (i == 3) chk("locked_w4", locked, 1);
            s = nxt(s);
        end
        chk("clean_par_cnt", par_cnt, 0);
        chk("clean_seq_cnt", seq_cnt, 0);

        cyc(1'b1, mk(s) ^ 8'h80, 1'b0);
        chk("par_pulse", par_err, 1);
        s = nxt(s);
        cyc(1'b1, mk(s), 1'b0);
        s = nxt(s);
        chk("par_pulse_end", par_err, 0);
        chk("par_cnt_1", par_cnt, 1);
        chk("par_seq_cnt_0", seq_cnt, 0);
        chk("par_locked", locked, 1);

        repeat (3) cyc(1'b0, 8'hA5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, mk(s), 1'b0);
            s = nxt(s);
        end
        chk("gap_seq_cnt", seq_cnt, 0);
        chk("gap_locked", locked, 1);

        c = (s == 7'h55) ? 7'h2A : 7'h55;
        cyc(1'b1, mk(c), 1'b0);
        chk("corrupt_seq_err", seq_err, 1);
        s = nxt(s);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, mk(s), 1'b0);
            s = nxt(s);
        end
        chk("corrupt_seq_cnt", seq_cnt, 1);
        chk("corrupt_locked", locked, 1);

        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, mk(s ^ 7'h01), 1'b0);
            s = nxt(s);
        end
        chk("loss_locked", locked, 0);
        chk("loss_seq_cnt", seq_cnt, 5);

        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, mk(s), 1'b0);
            s = nxt(s);
        end
        chk("relock", locked, 1);

        for (int i = 0; i < 15; i++) begin
            cyc(1'b1, mk(s) ^ 8'h80, 1'b0);
            s = nxt(s);
        end
        chk("par_sat", par_cnt, 15);

        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, mk(s ^ 7'h01), 1'b0);
            s = nxt(s);
            cyc(1'b1, mk(s), 1'b0);
            s = nxt(s);
        end
        chk("seq_sat", seq_cnt, 15);

        cyc(1'b1, mk(s ^ 7'h01), 1'b1);
        s = nxt(s);
        chk("clr_seq_err", seq_err, 1);
        chk("clr_seq_cnt", seq_cnt, 0);
        chk("clr_par_cnt", par_cnt, 0);

        cyc(1'b1, mk(s ^ 7'h01) ^ 8'h80, 1'b0);
        s = nxt(s);
        chk("both_par_err", par_err, 1);
        chk("both_seq_err", seq_err, 1);
        chk("both_par_cnt", par_cnt, 1);
        chk("both_seq_cnt", seq_cnt, 1);

        rst = 1'b0;
        #1;
        chk("arst_locked",  locked,  0);
        chk("arst_par_err", par_err, 0);
        chk("arst_seq_err", seq_err, 0);
        chk("arst_par_cnt", par_cnt, 0);
        chk("arst_seq_cnt", seq_cnt, 0);
        model_reset();
        #1;
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, mk(s), 1'b0);
            if (i == 2) chk("post_rst_not_locked", locked, 0);
            if (i == 3) chk("post_rst_locked", locked, 1);
            s = nxt(s);
        end

`ifdef LFSR_CHK_PERIOD_EN
        per_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            cyc(1'b1, mk(s), 1'b0);
            s = nxt(s);
        end
        per_en = 1'b0;
        chk("period_pulses", (nvld >= 2), 1);
`endif

        in_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
